// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout of a 256x256 grey framebuffer, centred with a black border.
// Latency RAM_LATENCY+2 from counter position to pins; enable=0 freezes position while the pipeline keeps shifting.
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int IMG_W       = 256,
    parameter int IMG_H       = 256,
    parameter int X_OFF       = 192,
    parameter int Y_OFF       = 112,
    parameter int RAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start
);

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic win;
        logic first;
    } flags_t;

    localparam flags_t FLAGS_RST = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, win: 1'b0, first: 1'b0};

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_BEG  = 10'(X_OFF);
    localparam logic [9:0] X_END  = 10'(X_OFF + IMG_W);
    localparam logic [9:0] Y_BEG  = 10'(Y_OFF);
    localparam logic [9:0] Y_END  = 10'(Y_OFF + IMG_H);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [15:0] ptr;
    flags_t      f0;
    flags_t      f1;
    flags_t      dly [RAM_LATENCY];
    flags_t      fl;
    logic [7:0]  pix;

    always_comb begin
        f0       = FLAGS_RST;
        f0.vis   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        f0.hs    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        f0.vs    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        f0.win   = (h_cnt >= X_BEG) && (h_cnt < X_END) && (v_cnt >= Y_BEG) && (v_cnt < Y_END);
        f0.first = (h_cnt == 10'd0) && (v_cnt == 10'd0) && enable;
    end

    // Pointer is zeroed on the edge entering (0,0) so it already reads 0 while parked there.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
            ptr   <= '0;
        end else if (enable) begin
            if (f0.win) begin
                ptr <= ptr + 16'd1;
            end
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                    ptr   <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            f1      <= FLAGS_RST;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                dly[i] <= FLAGS_RST;
            end
        end else begin
            rd_addr <= ptr;
            f1      <= f0;
            dly[0]  <= f1;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign fl  = dly[RAM_LATENCY-1];
    assign pix = (fl.win && fl.vis) ? rd_data : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= fl.hs;
            vsync       <= fl.vs;
            blank_n     <= fl.vis;
            red         <= pix;
            green       <= pix;
            blue        <= pix;
            frame_start <= fl.first;
        end
    end

    assign sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench: a reduced-timing instance checked cycle by cycle against a position scoreboard,
// plus a default 640x480 instance for reset values and line timing.
module tb_vga_scanout;

    localparam int HA  = 40;
    localparam int HFP = 4;
    localparam int HS  = 6;
    localparam int HBP = 6;
    localparam int VA  = 24;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int IW  = 16;
    localparam int IH  = 8;
    localparam int XO  = 12;
    localparam int YO  = 8;
    localparam int H_T = HA + HFP + HS + HBP;
    localparam int V_T = VA + VFP + VS + VBP;

    localparam logic [43:0] RST_OBS = {1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 16'h0000};

    typedef struct {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [7:0] c;
        logic       fs;
        int         h;
        int         v;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        hsync, vsync, blank_n, sync_n, frame_start;
    logic [7:0]  red, green, blue;

    logic [15:0] rd_addr_f;
    logic [7:0]  rd_data_f;
    logic        hsync_f, vsync_f, blank_n_f, sync_n_f, frame_start_f;
    logic [7:0]  red_f, green_f, blue_f;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t exp_cur;
    logic [15:0] exp_addr;
    int   mh = 0, mv = 0, ah = -1, av = -1;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .X_OFF(XO), .Y_OFF(YO), .RAM_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .rd_addr(rd_addr), .rd_data(rd_data),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    vga_scanout dut_full (
        .clk(clk), .reset(reset), .enable(enable), .rd_addr(rd_addr_f), .rd_data(rd_data_f),
        .hsync(hsync_f), .vsync(vsync_f), .blank_n(blank_n_f), .sync_n(sync_n_f),
        .red(red_f), .green(green_f), .blue(blue_f), .frame_start(frame_start_f)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Framebuffer contents are the low address byte, one cycle read latency.
    always @(posedge clk) begin
        rd_data   <= rd_addr[7:0];
        rd_data_f <= rd_addr_f[7:0];
    end

    function automatic logic [15:0] ptrf(int h, int v);
        int hh;
        if (v < YO) return 16'd0;
        if (v >= YO + IH) return 16'(IW * IH);
        hh = h - XO;
        if (hh < 0) hh = 0;
        if (hh > IW) hh = IW;
        return 16'((v - YO) * IW + hh);
    endfunction

    function automatic exp_t decode(int h, int v, logic en);
        exp_t e;
        logic [15:0] a;
        logic vis, win;
        vis  = (h < HA) && (v < VA);
        win  = (h >= XO) && (h < XO + IW) && (v >= YO) && (v < YO + IH);
        a    = ptrf(h, v);
        e.hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
        e.vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
        e.bl = vis;
        e.c  = (vis && win) ? a[7:0] : 8'h00;
        e.fs = (h == 0) && (v == 0) && en;
        e.h  = h;
        e.v  = v;
        return e;
    endfunction

    // Scoreboard: each edge pushes the decode of the position being captured, pops what the pins show now.
    always @(posedge clk) begin
        if (reset) begin
            cyc = 0;
            q.delete();
            exp_cur = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, c: 8'h00, fs: 1'b0, h: -1, v: -1};
            q.push_back(exp_cur);
            q.push_back(exp_cur);
            mh = 0; mv = 0; ah = -1; av = -1;
            exp_addr = 16'h0000;
        end else begin
            cyc = cyc + 1;
            q.push_back(decode(mh, mv, enable));
            exp_cur  = q.pop_front();
            exp_addr = ptrf(mh, mv);
            ah = mh; av = mv;
            if (enable) begin
                if (mh == H_T - 1) begin
                    mh = 0;
                    mv = (mv == V_T - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
        end
    end

    function automatic logic [44:0] obs_vec();
        return {hsync, vsync, blank_n, sync_n, red, green, blue, frame_start, rd_addr};
    endfunction

    function automatic logic [44:0] exp_vec();
        return {exp_cur.hs, exp_cur.vs, exp_cur.bl, 1'b0, exp_cur.c, exp_cur.c, exp_cur.c, exp_cur.fs, exp_addr};
    endfunction

    task automatic test_reset();
        int first;
        reset = 1'b1; enable = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_reset cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if ({hsync, vsync, blank_n, red, green, blue, frame_start, rd_addr} !== RST_OBS) begin
                errors++; $display("FAIL reset_vals got=%h exp=%h", {hsync, vsync, blank_n, red, green, blue, frame_start, rd_addr}, RST_OBS);
            end
            checks++;
            if ({hsync_f, vsync_f, blank_n_f, red_f, green_f, blue_f, frame_start_f, rd_addr_f, sync_n_f} !== {RST_OBS, 1'b0}) begin
                errors++; $display("FAIL reset_vals_full got=%h exp=%h", {hsync_f, vsync_f, blank_n_f, red_f, green_f, blue_f, frame_start_f, rd_addr_f, sync_n_f}, {RST_OBS, 1'b0});
            end
            checks++;
        end
        reset = 1'b0;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (frame_start === 1'b1) begin first = i; break; end
        end
        if (first != 3) begin errors++; $display("FAIL first_frame_start got=%0d exp=3", first); end
        checks++;
    endtask

    task automatic test_line_timing();
        int fall1 = -1, fall2 = -1, rise1 = -1, bl_cnt = 0;
        logic prev_hs = 1'b1;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_line cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (prev_hs && !hsync_f) begin
                if (fall1 < 0) fall1 = cyc; else if (fall2 < 0) fall2 = cyc;
            end
            if (!prev_hs && hsync_f && rise1 < 0) rise1 = cyc;
            prev_hs = hsync_f;
            if (cyc >= 803 && cyc < 1603 && blank_n_f) bl_cnt++;
        end
        if (fall1 != 659) begin errors++; $display("FAIL hsync_start got=%0d exp=659", fall1); end
        checks++;
        if (rise1 - fall1 != 96) begin errors++; $display("FAIL hsync_width got=%0d exp=96", rise1 - fall1); end
        checks++;
        if (fall2 - fall1 != 800) begin errors++; $display("FAIL line_period got=%0d exp=800", fall2 - fall1); end
        checks++;
        if (bl_cnt != 640) begin errors++; $display("FAIL blank_width got=%0d exp=640", bl_cnt); end
        checks++;
    endtask

    task automatic test_frame();
        int f1 = -1, f2 = -1, vfall = -1, vlow = 0;
        logic prev_vs = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_frame cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (frame_start === 1'b1) begin
                if (f1 < 0) f1 = cyc; else begin f2 = cyc; break; end
            end
            if (f1 >= 0 && !vsync) vlow++;
            if (f1 >= 0 && prev_vs && !vsync && vfall < 0) vfall = cyc - f1;
            prev_vs = vsync;
        end
        if (f2 < 0 || f2 - f1 != H_T * V_T) begin errors++; $display("FAIL frame_period got=%0d exp=%0d", f2 - f1, H_T * V_T); end
        checks++;
        if (vlow != VS * H_T) begin errors++; $display("FAIL vsync_width got=%0d exp=%0d", vlow, VS * H_T); end
        checks++;
        if (vfall != (VA + VFP) * H_T) begin errors++; $display("FAIL vsync_start got=%0d exp=%0d", vfall, (VA + VFP) * H_T); end
        checks++;
    endtask

    task automatic test_addressing();
        logic [5:0] hit = '0;
        enable = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_addr cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (exp_cur.h == XO && exp_cur.v == YO && !hit[0]) begin
                hit[0] = 1'b1; checks++;
                if (red !== 8'h00 || blank_n !== 1'b1) begin errors++; $display("FAIL pix_first got=%h/%b exp=00/1", red, blank_n); end
            end
            if (exp_cur.h == XO + 1 && exp_cur.v == YO && !hit[1]) begin
                hit[1] = 1'b1; checks++;
                if (green !== 8'h01) begin errors++; $display("FAIL pix_second got=%h exp=01", green); end
            end
            if (exp_cur.h == XO - 1 && exp_cur.v == YO && !hit[2]) begin
                hit[2] = 1'b1; checks++;
                if (blue !== 8'h00) begin errors++; $display("FAIL pix_left_border got=%h exp=00", blue); end
            end
            if (exp_cur.h == XO && exp_cur.v == YO + IH && !hit[3]) begin
                hit[3] = 1'b1; checks++;
                if (red !== 8'h00 || blank_n !== 1'b1) begin errors++; $display("FAIL pix_below got=%h/%b exp=00/1", red, blank_n); end
            end
            if (ah == XO + IW - 1 && av == YO + IH - 1 && !hit[4]) begin
                hit[4] = 1'b1; checks++;
                if (rd_addr !== 16'd127) begin errors++; $display("FAIL addr_last got=%0d exp=127", rd_addr); end
            end
            if (exp_cur.h == XO + IW - 1 && exp_cur.v == YO + IH - 1 && !hit[5]) begin
                hit[5] = 1'b1; checks++;
                if (red !== 8'h7f) begin errors++; $display("FAIL pix_last got=%h exp=7f", red); end
            end
        end
        if (hit != 6'b111111) begin errors++; $display("FAIL addr_spots_reached got=%b exp=111111", hit); end
        checks++;
    endtask

    task automatic test_freeze();
        logic found = 1'b0, seen = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_pre_freeze cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (mh == 20 && mv == 10) found = 1'b1;
        end
        if (!found) begin errors++; $display("FAIL freeze_reach got=0 exp=1"); end
        checks++;
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_freeze cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (rd_addr !== 16'd40 || dut.h_cnt !== 10'd20 || dut.v_cnt !== 10'd10) begin
                errors++; $display("FAIL freeze_hold got=%0d,%0d,%0d exp=40,20,10", rd_addr, dut.h_cnt, dut.v_cnt);
            end
            checks++;
        end
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_resume cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (exp_cur.h == 21 && exp_cur.v == 10 && !seen) begin
                seen = 1'b1;
                if (red !== 8'd41) begin errors++; $display("FAIL resume_pixel got=%0d exp=41", red); end
                checks++;
            end
        end
        if (!seen) begin errors++; $display("FAIL resume_reach got=0 exp=1"); end
        checks++;
    endtask

    task automatic test_random_enable();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_rand_en cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            enable = ($urandom_range(0, 3) != 0);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        int first = -1;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_pre_rst cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (mh == 5 && mv == 12) found = 1'b1;
        end
        if (!found) begin errors++; $display("FAIL rst_mid_reach got=0 exp=1"); end
        checks++;
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) reset = 1'b0;
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_rst_mid cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (i <= 4) begin
                if ({hsync, vsync, blank_n, red, green, blue, frame_start, rd_addr} !== RST_OBS) begin
                    errors++; $display("FAIL rst_mid_vals i=%0d got=%h exp=%h", i, {hsync, vsync, blank_n, red, green, blue, frame_start, rd_addr}, RST_OBS);
                end
                checks++;
            end
            if (i > 2 && frame_start === 1'b1) begin first = i - 2; break; end
        end
        if (first != 3) begin errors++; $display("FAIL rst_mid_frame_start got=%0d exp=3", first); end
        checks++;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sb_post_rst cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            checks++;
            if (ah == XO && av == YO) begin
                found = 1'b1;
                if (rd_addr !== 16'd0) begin errors++; $display("FAIL rst_mid_addr got=%0d exp=0", rd_addr); end
                checks++;
            end
        end
        if (!found) begin errors++; $display("FAIL rst_mid_addr_reach got=0 exp=1"); end
        checks++;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        test_reset();
        test_line_timing();
        test_frame();
        test_addressing();
        test_freeze();
        test_random_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog cyc=%0d exp=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
